// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared mode encodings and pointer helper for the priority encoder
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Round-robin successor: the search moves downward and wraps from 0 to n-1.
  function automatic int nxt_ptr(input int g, input int n);
    return (g == 0) ? n - 1 : g - 1;
  endfunction

endpackage

// File: rtl/prio_scan.sv
// rtl/prio_scan.sv - combinational rotated highest-first request scan
module prio_scan
  import prio_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          hit
);

  logic [IW-1:0] w_start;
  logic [IW-1:0] w_pos;

  // A start beyond the last requester can only come from a corrupted pointer; treat it as N-1.
  assign w_start = (start >= IW'(N - 1)) ? IW'(N - 1) : start;

  always_comb begin
    idx   = '0;
    hit   = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(w_start) >= k) w_pos = IW'(int'(w_start) - k);
      else                    w_pos = IW'(int'(w_start) + N - k);
      if (!hit && req[w_pos]) begin
        hit = 1'b1;
        idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/prio_enc_rr.sv
// rtl/prio_enc_rr.sv - registered fixed/round-robin priority encoder with valid/ready output
module prio_enc_rr
  import prio_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic [N-1:0]  req,
  output logic          any_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_onehot
);

  logic          r_valid;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_onehot;
  logic [IW-1:0] r_ptr;

  logic          w_hs;
  logic          w_ld;
  logic [IW-1:0] w_ptr_nxt;
  logic [IW-1:0] w_ptr_eff;
  logic [IW-1:0] w_fix_idx;
  logic          w_fix_hit;
  logic [IW-1:0] w_rr_idx;
  logic          w_rr_hit;
  logic [IW-1:0] w_idx;
  logic          w_hit;
  logic [N-1:0]  w_onehot;

  assign any_req   = |req;
  assign w_hs      = r_valid & out_ready;
  assign w_ptr_nxt = IW'(nxt_ptr(int'(r_idx), N));
  // On a round-robin handshake the pointer update has not landed yet, so bypass it.
  assign w_ptr_eff = (w_hs && mode == MODE_RR) ? w_ptr_nxt : r_ptr;

  prio_scan #(.N(N), .IW(IW)) u_scan_fix (
    .req   (req),
    .start (IW'(N - 1)),
    .idx   (w_fix_idx),
    .hit   (w_fix_hit)
  );

  prio_scan #(.N(N), .IW(IW)) u_scan_rr (
    .req   (req),
    .start (w_ptr_eff),
    .idx   (w_rr_idx),
    .hit   (w_rr_hit)
  );

  assign w_idx = (mode == MODE_RR) ? w_rr_idx : w_fix_idx;
  assign w_hit = (mode == MODE_RR) ? w_rr_hit : w_fix_hit;
  // A scan hit is exactly any_req, since both scans cover every requester.
  assign w_ld  = en & any_req & w_hit & (~r_valid | out_ready);

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= IW'(N - 1);
    end else begin
      if (w_ld) begin
        r_valid  <= 1'b1;
        r_idx    <= w_idx;
        r_onehot <= w_onehot;
      end else if (w_hs) begin
        r_valid  <= 1'b0;
      end
      if (w_hs && mode == MODE_RR) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb/tb_prio_enc_rr.sv - scoreboard bench for prio_enc_rr at N=8 and N=5
module tb_prio_enc_rr;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       out_ready;
  logic [7:0] req8;
  logic       any8;
  logic       v8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       any5;
  logic       v5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int checks = 0;
  int errors = 0;

  int NN [2];
  bit m_valid [2];
  int m_idx [2];
  int m_ptr [2];
  int sb0 [$];
  int sb1 [$];

  prio_enc_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req8), .any_req(any8),
    .out_valid(v8), .out_ready(out_ready), .out_idx(idx8), .out_onehot(oh8)
  );

  prio_enc_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req5), .any_req(any5),
    .out_valid(v5), .out_ready(out_ready), .out_idx(idx5), .out_onehot(oh5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Requesters visited from start downward, wrapping past 0 to n-1.
  function automatic int pick(input logic [7:0] r, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (start - k + n) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    NN[0] = 8; NN[1] = 5;
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0;
      m_idx[u]   = 0;
      m_ptr[u]   = NN[u] - 1;
    end
    sb0.delete();
    sb1.delete();
  endtask

  // Called at posedge+2; returns at the following posedge+2.
  task automatic step(input bit e, input bit m, input logic [7:0] r, input bit rd,
                      input int x0, input int x1);
    bit         ld [2];
    bit         hs;
    int         start;
    logic [7:0] ru;
    en = e; mode = m; req8 = r; req5 = r[4:0]; out_ready = rd;
    #1;
    check("any_req8", any8, (r != 0));
    check("any_req5", any5, (r[4:0] != 0));
    for (int u = 0; u < 2; u++) begin
      ru    = (u == 0) ? r : {3'b000, r[4:0]};
      hs    = m_valid[u] && rd;
      if (!m)      start = NN[u] - 1;
      else if (hs) start = (m_idx[u] + NN[u] - 1) % NN[u];
      else         start = m_ptr[u];
      ld[u] = e && (ru != 0) && (!m_valid[u] || rd);
      if (hs && m) m_ptr[u] = (m_idx[u] + NN[u] - 1) % NN[u];
      if (ld[u]) begin
        m_idx[u]   = pick(ru, start, NN[u]);
        m_valid[u] = 1'b1;
      end else if (hs) begin
        m_valid[u] = 1'b0;
      end
    end
    @(posedge clk);
    if (ld[0]) sb0.push_back((x0 >= 0) ? x0 : m_idx[0]);
    if (ld[1]) sb1.push_back((x1 >= 0) ? x1 : m_idx[1]);
    #2;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid8", v8, (sb0.size() != 0));
        if (v8 && sb0.size() != 0) begin
          check("idx8", idx8, sb0[0]);
          check("onehot8", oh8, 32'd1 << sb0[0]);
          if (out_ready) void'(sb0.pop_front());
        end
        check("valid5", v5, (sb1.size() != 0));
        if (v5) check("range5", (idx5 < 3'd5), 1);
        if (v5 && sb1.size() != 0) begin
          check("idx5", idx5, sb1[0]);
          check("onehot5", oh5, 32'd1 << sb1[0]);
          if (out_ready) void'(sb1.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; out_ready = 1'b0; req8 = '0; req5 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid8", v8, 0);
    check("rst_idx8", idx8, 0);
    check("rst_onehot8", oh8, 0);
    check("rst_ptr8", dut8.r_ptr, 7);
    check("rst_ptr5", dut5.r_ptr, 4);
    #1 rst_n = 1'b1;

    // fixed mode, then backpressure hold while req changes
    step(1, 0, 8'h24, 1, 5, -1);
    repeat (3) step(1, 0, 8'h80, 0, -1, -1);
    step(1, 0, 8'h80, 1, 7, -1);
    step(0, 0, 8'h00, 1, -1, -1);

    // round-robin full sweep
    step(1, 1, 8'hFF, 1, 7, -1);
    step(1, 1, 8'hFF, 1, 6, -1);
    step(1, 1, 8'hFF, 1, 5, -1);
    step(1, 1, 8'hFF, 1, 4, -1);
    step(1, 1, 8'hFF, 1, 3, -1);
    step(1, 1, 8'hFF, 1, 2, -1);
    step(1, 1, 8'hFF, 1, 1, -1);
    step(1, 1, 8'hFF, 1, 0, -1);
    step(1, 1, 8'hFF, 1, 7, -1);
    step(0, 0, 8'h00, 1, -1, -1);

    // two requesters alternate, then fixed mode sticks to the top one
    step(1, 1, 8'h81, 1, 7, -1);
    step(1, 1, 8'h81, 1, 0, -1);
    step(1, 1, 8'h81, 1, 7, -1);
    step(1, 1, 8'h81, 1, 0, -1);
    step(1, 0, 8'h81, 1, 7, -1);
    step(1, 0, 8'h81, 1, 7, -1);
    step(1, 0, 8'h81, 1, 7, -1);
    step(0, 0, 8'h00, 1, -1, -1);

    // en low after a grant lets the pending grant drain
    step(1, 0, 8'h24, 1, 5, -1);
    step(0, 0, 8'h24, 1, -1, -1);
    step(1, 0, 8'h00, 1, -1, -1);

    // asynchronous reset while a grant is held
    step(1, 0, 8'h24, 1, 5, -1);
    step(1, 0, 8'h24, 0, -1, -1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid8", v8, 0);
    check("midrst_ptr8", dut8.r_ptr, 7);
    check("midrst_valid5", v5, 0);
    check("midrst_ptr5", dut5.r_ptr, 4);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // N=5 round-robin wrap
    step(1, 1, 8'h11, 1, -1, 4);
    step(1, 1, 8'h11, 1, -1, 0);
    step(1, 1, 8'h11, 1, -1, 4);
    step(0, 1, 8'h00, 1, -1, -1);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(5) == 0) r = '0;
      step(($urandom_range(7) != 0), 1'($urandom), r, ($urandom_range(3) != 0), -1, -1);
    end

    step(0, 0, 8'h00, 1, -1, -1);
    step(0, 0, 8'h00, 1, -1, -1);
    check("drain8", sb0.size(), 0);
    check("drain5", sb1.size(), 0);
    check("final_valid8", v8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
